// File: rtl/mmio_acquire_arbiter_pkg.sv
// Shared types, TileLink field widths and beat-completion helpers for the
// two-client MMIO acquire arbiter.
package mmio_acquire_arbiter_pkg;

    localparam int ADDR_BLOCK_W = 26;
    localparam int BEAT_W       = 3;
    localparam int UNION_W      = 12;
    localparam int DATA_W       = 64;

    localparam logic [2:0] A_TYPE_PUT_BLOCK      = 3'd3;
    localparam logic [3:0] G_TYPE_GET_DATA_BLOCK = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic logic acq_multibeat(input logic isBuiltin, input logic [2:0] aType);
        return isBuiltin && (aType == A_TYPE_PUT_BLOCK);
    endfunction

    function automatic logic acq_done(input logic isBuiltin, input logic [2:0] aType,
                                      input logic [BEAT_W-1:0] beat,
                                      input logic [BEAT_W-1:0] lastBeat);
        return !acq_multibeat(isBuiltin, aType) || (beat == lastBeat);
    endfunction

    function automatic logic gnt_multibeat(input logic isBuiltin, input logic [3:0] gType);
        return isBuiltin && (gType == G_TYPE_GET_DATA_BLOCK);
    endfunction

    function automatic logic gnt_done(input logic isBuiltin, input logic [3:0] gType,
                                      input logic [BEAT_W-1:0] beat,
                                      input logic [BEAT_W-1:0] lastBeat);
        return !gnt_multibeat(isBuiltin, gType) || (beat == lastBeat);
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin pointer plus burst lock: picks which client drives the inner
// acquire channel and keeps a Put-block owner selected until its last beat.
module rr_lock_arbiter
    import mmio_acquire_arbiter_pkg::*;
#(
    parameter int BEATS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] acqValid_i,
    input  logic [1:0] belowCap_i,
    input  logic       outReady_i,
    input  logic       selMultibeat_i,
    input  logic       selFirstBeat_i,
    input  logic       selDone_i,
    output logic       sel_o,
    output logic       outValid_o,
    output logic [1:0] inReady_o,
    output logic       fire_o
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       rrPtr_q, rrPtr_d;

    logic [1:0] burstMask;
    logic [1:0] eligible;
    logic       sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rrPtr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rrPtr_d    = rrPtr_q;
        sel        = rrPtr_q;
        inReady_o  = 2'b00;

        // The burst owner may exceed its outstanding cap to finish its block.
        burstMask  = (state_q == BURST) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        eligible   = acqValid_i & (belowCap_i | burstMask);

        if (state_q == BURST) begin
            sel = owner_q;
        end else if (eligible[rrPtr_q]) begin
            sel = rrPtr_q;
        end else if (eligible[~rrPtr_q]) begin
            sel = ~rrPtr_q;
        end

        outValid_o     = eligible[sel];
        inReady_o[sel] = outReady_i && eligible[sel];
        fire_o         = outValid_o && outReady_i;

        case (state_q)
            IDLE: begin
                if (fire_o) begin
                    if (selMultibeat_i && selFirstBeat_i && (BEATS > 1)) begin
                        state_d = BURST;
                        owner_d = sel;
                    end else if (selDone_i) begin
                        rrPtr_d = ~sel;
                    end
                end
            end
            BURST: begin
                if (fire_o && selDone_i) begin
                    state_d = IDLE;
                    rrPtr_d = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_o = sel;

endmodule

// File: rtl/mmio_acquire_arbiter.sv
// Two-client uncached TileLink arbiter: merges acquires onto one inner port,
// caps outstanding transactions per client and steers grants back by client_id.
module mmio_acquire_arbiter
    import mmio_acquire_arbiter_pkg::*;
#(
    parameter int BEATS           = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    io_in_0_acquire_valid,
    output logic                    io_in_0_acquire_ready,
    input  logic [ADDR_BLOCK_W-1:0] io_in_0_acquire_bits_addr_block,
    input  logic                    io_in_0_acquire_bits_client_xact_id,
    input  logic [BEAT_W-1:0]       io_in_0_acquire_bits_addr_beat,
    input  logic                    io_in_0_acquire_bits_is_builtin_type,
    input  logic [2:0]              io_in_0_acquire_bits_a_type,
    input  logic [UNION_W-1:0]      io_in_0_acquire_bits_union,
    input  logic [DATA_W-1:0]       io_in_0_acquire_bits_data,

    input  logic                    io_in_1_acquire_valid,
    output logic                    io_in_1_acquire_ready,
    input  logic [ADDR_BLOCK_W-1:0] io_in_1_acquire_bits_addr_block,
    input  logic                    io_in_1_acquire_bits_client_xact_id,
    input  logic [BEAT_W-1:0]       io_in_1_acquire_bits_addr_beat,
    input  logic                    io_in_1_acquire_bits_is_builtin_type,
    input  logic [2:0]              io_in_1_acquire_bits_a_type,
    input  logic [UNION_W-1:0]      io_in_1_acquire_bits_union,
    input  logic [DATA_W-1:0]       io_in_1_acquire_bits_data,

    output logic                    io_out_acquire_valid,
    input  logic                    io_out_acquire_ready,
    output logic [ADDR_BLOCK_W-1:0] io_out_acquire_bits_addr_block,
    output logic                    io_out_acquire_bits_client_xact_id,
    output logic [BEAT_W-1:0]       io_out_acquire_bits_addr_beat,
    output logic                    io_out_acquire_bits_is_builtin_type,
    output logic [2:0]              io_out_acquire_bits_a_type,
    output logic [UNION_W-1:0]      io_out_acquire_bits_union,
    output logic [DATA_W-1:0]       io_out_acquire_bits_data,
    output logic                    io_out_acquire_bits_client_id,

    input  logic                    io_out_grant_valid,
    output logic                    io_out_grant_ready,
    input  logic [BEAT_W-1:0]       io_out_grant_bits_addr_beat,
    input  logic                    io_out_grant_bits_client_xact_id,
    input  logic [1:0]              io_out_grant_bits_manager_xact_id,
    input  logic                    io_out_grant_bits_is_builtin_type,
    input  logic [3:0]              io_out_grant_bits_g_type,
    input  logic [DATA_W-1:0]       io_out_grant_bits_data,
    input  logic                    io_out_grant_bits_client_id,

    output logic                    io_in_0_grant_valid,
    input  logic                    io_in_0_grant_ready,
    output logic [BEAT_W-1:0]       io_in_0_grant_bits_addr_beat,
    output logic                    io_in_0_grant_bits_client_xact_id,
    output logic [1:0]              io_in_0_grant_bits_manager_xact_id,
    output logic                    io_in_0_grant_bits_is_builtin_type,
    output logic [3:0]              io_in_0_grant_bits_g_type,
    output logic [DATA_W-1:0]       io_in_0_grant_bits_data,

    output logic                    io_in_1_grant_valid,
    input  logic                    io_in_1_grant_ready,
    output logic [BEAT_W-1:0]       io_in_1_grant_bits_addr_beat,
    output logic                    io_in_1_grant_bits_client_xact_id,
    output logic [1:0]              io_in_1_grant_bits_manager_xact_id,
    output logic                    io_in_1_grant_bits_is_builtin_type,
    output logic [3:0]              io_in_1_grant_bits_g_type,
    output logic [DATA_W-1:0]       io_in_1_grant_bits_data,

    input  logic                    io_in_0_finish_valid,
    output logic                    io_in_0_finish_ready,
    input  logic [1:0]              io_in_0_finish_bits_manager_xact_id,
    input  logic                    io_in_1_finish_valid,
    output logic                    io_in_1_finish_ready,
    input  logic [1:0]              io_in_1_finish_bits_manager_xact_id,

    output logic                    io_out_finish_valid,
    input  logic                    io_out_finish_ready,
    output logic [1:0]              io_out_finish_bits_manager_xact_id
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [1:0]        CAP       = 2'(MAX_OUTSTANDING);

    logic       sel;
    logic       acqFire;
    logic [1:0] inReady;
    logic       selDone;
    logic       gntFire;
    logic       gntDone;
    logic [1:0] acqInc;
    logic [1:0] gntDec;
    logic [1:0] cnt0_q, cnt0_d;
    logic [1:0] cnt1_q, cnt1_d;

    function automatic logic [1:0] nextCount(input logic [1:0] cur, input logic inc,
                                             input logic dec);
        logic [1:0] res;
        res = cur;
        if (inc && !dec && cur != 2'd3) res = cur + 2'd1;
        if (dec && !inc && cur != 2'd0) res = cur - 2'd1;
        return res;
    endfunction

    assign io_out_acquire_bits_addr_block      = sel ? io_in_1_acquire_bits_addr_block      : io_in_0_acquire_bits_addr_block;
    assign io_out_acquire_bits_client_xact_id  = sel ? io_in_1_acquire_bits_client_xact_id  : io_in_0_acquire_bits_client_xact_id;
    assign io_out_acquire_bits_addr_beat       = sel ? io_in_1_acquire_bits_addr_beat       : io_in_0_acquire_bits_addr_beat;
    assign io_out_acquire_bits_is_builtin_type = sel ? io_in_1_acquire_bits_is_builtin_type : io_in_0_acquire_bits_is_builtin_type;
    assign io_out_acquire_bits_a_type          = sel ? io_in_1_acquire_bits_a_type          : io_in_0_acquire_bits_a_type;
    assign io_out_acquire_bits_union           = sel ? io_in_1_acquire_bits_union           : io_in_0_acquire_bits_union;
    assign io_out_acquire_bits_data            = sel ? io_in_1_acquire_bits_data            : io_in_0_acquire_bits_data;
    assign io_out_acquire_bits_client_id       = sel;

    assign selDone = acq_done(io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type,
                              io_out_acquire_bits_addr_beat, LAST_BEAT);

    rr_lock_arbiter #(.BEATS(BEATS)) u_arb (
        .clk            (clk),
        .reset          (reset),
        .acqValid_i     ({io_in_1_acquire_valid, io_in_0_acquire_valid}),
        .belowCap_i     ({cnt1_q < CAP, cnt0_q < CAP}),
        .outReady_i     (io_out_acquire_ready),
        .selMultibeat_i (acq_multibeat(io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type)),
        .selFirstBeat_i (io_out_acquire_bits_addr_beat == '0),
        .selDone_i      (selDone),
        .sel_o          (sel),
        .outValid_o     (io_out_acquire_valid),
        .inReady_o      (inReady),
        .fire_o         (acqFire)
    );

    assign io_in_0_acquire_ready = inReady[0];
    assign io_in_1_acquire_ready = inReady[1];

    assign io_in_0_grant_valid = io_out_grant_valid && !io_out_grant_bits_client_id;
    assign io_in_1_grant_valid = io_out_grant_valid &&  io_out_grant_bits_client_id;
    assign io_out_grant_ready  = io_out_grant_bits_client_id ? io_in_1_grant_ready : io_in_0_grant_ready;

    assign io_in_0_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
    assign io_in_0_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id;
    assign io_in_0_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
    assign io_in_0_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
    assign io_in_0_grant_bits_g_type          = io_out_grant_bits_g_type;
    assign io_in_0_grant_bits_data            = io_out_grant_bits_data;
    assign io_in_1_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
    assign io_in_1_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id;
    assign io_in_1_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
    assign io_in_1_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
    assign io_in_1_grant_bits_g_type          = io_out_grant_bits_g_type;
    assign io_in_1_grant_bits_data            = io_out_grant_bits_data;

    // A multibeat grant only releases its outstanding slot on the final beat.
    always_comb begin
        gntFire = io_out_grant_valid && io_out_grant_ready;
        gntDone = gnt_done(io_out_grant_bits_is_builtin_type, io_out_grant_bits_g_type,
                           io_out_grant_bits_addr_beat, LAST_BEAT);
        acqInc  = {acqFire && selDone && sel, acqFire && selDone && !sel};
        gntDec  = {gntFire && gntDone && io_out_grant_bits_client_id,
                   gntFire && gntDone && !io_out_grant_bits_client_id};
        cnt0_d  = nextCount(cnt0_q, acqInc[0], gntDec[0]);
        cnt1_d  = nextCount(cnt1_q, acqInc[1], gntDec[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 2'd0;
            cnt1_q <= 2'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // A grant with nothing outstanding means the manager lost track of a client.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(gntDec[0] && !acqInc[0] && cnt0_q == 2'd0));
            assert (!(gntDec[1] && !acqInc[1] && cnt1_q == 2'd0));
        end
    end

    assign io_out_finish_valid                = io_in_0_finish_valid || io_in_1_finish_valid;
    assign io_out_finish_bits_manager_xact_id = io_in_0_finish_valid ? io_in_0_finish_bits_manager_xact_id
                                                                     : io_in_1_finish_bits_manager_xact_id;
    assign io_in_0_finish_ready               = io_out_finish_ready;
    assign io_in_1_finish_ready               = io_out_finish_ready && !io_in_0_finish_valid;

endmodule

// File: tb/tb_mmio_acquire_arbiter.sv
// Directed bench for mmio_acquire_arbiter: round-robin order, burst locking,
// outstanding caps, grant steering, reset mid-burst and finish priority.
module tb_mmio_acquire_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        io_in_0_acquire_valid, io_in_0_acquire_ready;
    logic [25:0] io_in_0_acquire_bits_addr_block;
    logic        io_in_0_acquire_bits_client_xact_id;
    logic [2:0]  io_in_0_acquire_bits_addr_beat;
    logic        io_in_0_acquire_bits_is_builtin_type;
    logic [2:0]  io_in_0_acquire_bits_a_type;
    logic [11:0] io_in_0_acquire_bits_union;
    logic [63:0] io_in_0_acquire_bits_data;
    logic        io_in_1_acquire_valid, io_in_1_acquire_ready;
    logic [25:0] io_in_1_acquire_bits_addr_block;
    logic        io_in_1_acquire_bits_client_xact_id;
    logic [2:0]  io_in_1_acquire_bits_addr_beat;
    logic        io_in_1_acquire_bits_is_builtin_type;
    logic [2:0]  io_in_1_acquire_bits_a_type;
    logic [11:0] io_in_1_acquire_bits_union;
    logic [63:0] io_in_1_acquire_bits_data;

    logic        io_out_acquire_valid, io_out_acquire_ready;
    logic [25:0] io_out_acquire_bits_addr_block;
    logic        io_out_acquire_bits_client_xact_id;
    logic [2:0]  io_out_acquire_bits_addr_beat;
    logic        io_out_acquire_bits_is_builtin_type;
    logic [2:0]  io_out_acquire_bits_a_type;
    logic [11:0] io_out_acquire_bits_union;
    logic [63:0] io_out_acquire_bits_data;
    logic        io_out_acquire_bits_client_id;

    logic        io_out_grant_valid, io_out_grant_ready;
    logic [2:0]  io_out_grant_bits_addr_beat;
    logic        io_out_grant_bits_client_xact_id;
    logic [1:0]  io_out_grant_bits_manager_xact_id;
    logic        io_out_grant_bits_is_builtin_type;
    logic [3:0]  io_out_grant_bits_g_type;
    logic [63:0] io_out_grant_bits_data;
    logic        io_out_grant_bits_client_id;

    logic        io_in_0_grant_valid, io_in_0_grant_ready;
    logic [2:0]  io_in_0_grant_bits_addr_beat;
    logic        io_in_0_grant_bits_client_xact_id;
    logic [1:0]  io_in_0_grant_bits_manager_xact_id;
    logic        io_in_0_grant_bits_is_builtin_type;
    logic [3:0]  io_in_0_grant_bits_g_type;
    logic [63:0] io_in_0_grant_bits_data;
    logic        io_in_1_grant_valid, io_in_1_grant_ready;
    logic [2:0]  io_in_1_grant_bits_addr_beat;
    logic        io_in_1_grant_bits_client_xact_id;
    logic [1:0]  io_in_1_grant_bits_manager_xact_id;
    logic        io_in_1_grant_bits_is_builtin_type;
    logic [3:0]  io_in_1_grant_bits_g_type;
    logic [63:0] io_in_1_grant_bits_data;

    logic        io_in_0_finish_valid, io_in_0_finish_ready;
    logic [1:0]  io_in_0_finish_bits_manager_xact_id;
    logic        io_in_1_finish_valid, io_in_1_finish_ready;
    logic [1:0]  io_in_1_finish_bits_manager_xact_id;
    logic        io_out_finish_valid, io_out_finish_ready;
    logic [1:0]  io_out_finish_bits_manager_xact_id;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    mmio_acquire_arbiter #(.BEATS(8), .MAX_OUTSTANDING(2)) dut (
        .clk                                  (clk),
        .reset                                (reset),
        .io_in_0_acquire_valid                (io_in_0_acquire_valid),
        .io_in_0_acquire_ready                (io_in_0_acquire_ready),
        .io_in_0_acquire_bits_addr_block      (io_in_0_acquire_bits_addr_block),
        .io_in_0_acquire_bits_client_xact_id  (io_in_0_acquire_bits_client_xact_id),
        .io_in_0_acquire_bits_addr_beat       (io_in_0_acquire_bits_addr_beat),
        .io_in_0_acquire_bits_is_builtin_type (io_in_0_acquire_bits_is_builtin_type),
        .io_in_0_acquire_bits_a_type          (io_in_0_acquire_bits_a_type),
        .io_in_0_acquire_bits_union           (io_in_0_acquire_bits_union),
        .io_in_0_acquire_bits_data            (io_in_0_acquire_bits_data),
        .io_in_1_acquire_valid                (io_in_1_acquire_valid),
        .io_in_1_acquire_ready                (io_in_1_acquire_ready),
        .io_in_1_acquire_bits_addr_block      (io_in_1_acquire_bits_addr_block),
        .io_in_1_acquire_bits_client_xact_id  (io_in_1_acquire_bits_client_xact_id),
        .io_in_1_acquire_bits_addr_beat       (io_in_1_acquire_bits_addr_beat),
        .io_in_1_acquire_bits_is_builtin_type (io_in_1_acquire_bits_is_builtin_type),
        .io_in_1_acquire_bits_a_type          (io_in_1_acquire_bits_a_type),
        .io_in_1_acquire_bits_union           (io_in_1_acquire_bits_union),
        .io_in_1_acquire_bits_data            (io_in_1_acquire_bits_data),
        .io_out_acquire_valid                 (io_out_acquire_valid),
        .io_out_acquire_ready                 (io_out_acquire_ready),
        .io_out_acquire_bits_addr_block       (io_out_acquire_bits_addr_block),
        .io_out_acquire_bits_client_xact_id   (io_out_acquire_bits_client_xact_id),
        .io_out_acquire_bits_addr_beat        (io_out_acquire_bits_addr_beat),
        .io_out_acquire_bits_is_builtin_type  (io_out_acquire_bits_is_builtin_type),
        .io_out_acquire_bits_a_type           (io_out_acquire_bits_a_type),
        .io_out_acquire_bits_union            (io_out_acquire_bits_union),
        .io_out_acquire_bits_data             (io_out_acquire_bits_data),
        .io_out_acquire_bits_client_id        (io_out_acquire_bits_client_id),
        .io_out_grant_valid                   (io_out_grant_valid),
        .io_out_grant_ready                   (io_out_grant_ready),
        .io_out_grant_bits_addr_beat          (io_out_grant_bits_addr_beat),
        .io_out_grant_bits_client_xact_id     (io_out_grant_bits_client_xact_id),
        .io_out_grant_bits_manager_xact_id    (io_out_grant_bits_manager_xact_id),
        .io_out_grant_bits_is_builtin_type    (io_out_grant_bits_is_builtin_type),
        .io_out_grant_bits_g_type             (io_out_grant_bits_g_type),
        .io_out_grant_bits_data               (io_out_grant_bits_data),
        .io_out_grant_bits_client_id          (io_out_grant_bits_client_id),
        .io_in_0_grant_valid                  (io_in_0_grant_valid),
        .io_in_0_grant_ready                  (io_in_0_grant_ready),
        .io_in_0_grant_bits_addr_beat         (io_in_0_grant_bits_addr_beat),
        .io_in_0_grant_bits_client_xact_id    (io_in_0_grant_bits_client_xact_id),
        .io_in_0_grant_bits_manager_xact_id   (io_in_0_grant_bits_manager_xact_id),
        .io_in_0_grant_bits_is_builtin_type   (io_in_0_grant_bits_is_builtin_type),
        .io_in_0_grant_bits_g_type            (io_in_0_grant_bits_g_type),
        .io_in_0_grant_bits_data              (io_in_0_grant_bits_data),
        .io_in_1_grant_valid                  (io_in_1_grant_valid),
        .io_in_1_grant_ready                  (io_in_1_grant_ready),
        .io_in_1_grant_bits_addr_beat         (io_in_1_grant_bits_addr_beat),
        .io_in_1_grant_bits_client_xact_id    (io_in_1_grant_bits_client_xact_id),
        .io_in_1_grant_bits_manager_xact_id   (io_in_1_grant_bits_manager_xact_id),
        .io_in_1_grant_bits_is_builtin_type   (io_in_1_grant_bits_is_builtin_type),
        .io_in_1_grant_bits_g_type            (io_in_1_grant_bits_g_type),
        .io_in_1_grant_bits_data              (io_in_1_grant_bits_data),
        .io_in_0_finish_valid                 (io_in_0_finish_valid),
        .io_in_0_finish_ready                 (io_in_0_finish_ready),
        .io_in_0_finish_bits_manager_xact_id  (io_in_0_finish_bits_manager_xact_id),
        .io_in_1_finish_valid                 (io_in_1_finish_valid),
        .io_in_1_finish_ready                 (io_in_1_finish_ready),
        .io_in_1_finish_bits_manager_xact_id  (io_in_1_finish_bits_manager_xact_id),
        .io_out_finish_valid                  (io_out_finish_valid),
        .io_out_finish_ready                  (io_out_finish_ready),
        .io_out_finish_bits_manager_xact_id   (io_out_finish_bits_manager_xact_id)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one client's acquire; payload fields are derived from the address
    // so the output mux can be checked against a known pattern.
    task automatic applyStimulus(input int k, input logic valid, input logic [2:0] aType,
                                 input logic [2:0] beat, input logic [25:0] addr);
        if (k == 0) begin
            io_in_0_acquire_valid                = valid;
            io_in_0_acquire_bits_addr_block      = addr;
            io_in_0_acquire_bits_client_xact_id  = 1'b0;
            io_in_0_acquire_bits_addr_beat       = beat;
            io_in_0_acquire_bits_is_builtin_type = 1'b1;
            io_in_0_acquire_bits_a_type          = aType;
            io_in_0_acquire_bits_union           = 12'hA50;
            io_in_0_acquire_bits_data            = {32'hC0DE_0000, 6'd0, addr};
        end else begin
            io_in_1_acquire_valid                = valid;
            io_in_1_acquire_bits_addr_block      = addr;
            io_in_1_acquire_bits_client_xact_id  = 1'b1;
            io_in_1_acquire_bits_addr_beat       = beat;
            io_in_1_acquire_bits_is_builtin_type = 1'b1;
            io_in_1_acquire_bits_a_type          = aType;
            io_in_1_acquire_bits_union           = 12'hA51;
            io_in_1_acquire_bits_data            = {32'hC0DE_0001, 6'd0, addr};
        end
    endtask

    task automatic applyGrant(input logic valid, input logic clientId, input logic [3:0] gType,
                              input logic [2:0] beat);
        io_out_grant_valid                = valid;
        io_out_grant_bits_client_id       = clientId;
        io_out_grant_bits_g_type          = gType;
        io_out_grant_bits_addr_beat       = beat;
        io_out_grant_bits_is_builtin_type = 1'b1;
        io_out_grant_bits_client_xact_id  = clientId;
        io_out_grant_bits_manager_xact_id = 2'd2;
        io_out_grant_bits_data            = {32'hBEEF_0000, 29'd0, beat};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 1'b0, 3'd0, 3'd0, 26'd0);
        applyStimulus(1, 1'b0, 3'd0, 3'd0, 26'd0);
        applyGrant(1'b0, 1'b0, 4'd0, 3'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        io_out_acquire_ready = 1'b1;
        io_in_0_grant_ready  = 1'b1;
        io_in_1_grant_ready  = 1'b1;
        io_out_finish_ready  = 1'b1;
        io_in_0_finish_valid = 1'b0;
        io_in_1_finish_valid = 1'b0;
        io_in_0_finish_bits_manager_xact_id = 2'd0;
        io_in_1_finish_bits_manager_xact_id = 2'd0;
        applyStimulus(0, 1'b0, 3'd0, 3'd0, 26'd0);
        applyStimulus(1, 1'b0, 3'd0, 3'd0, 26'd0);
        applyGrant(1'b0, 1'b0, 4'd0, 3'd0);
        tick();
        tick();
        settle();
        checkOutput("rst_out_valid", 64'(io_out_acquire_valid), 64'd0);
        checkOutput("rst_in0_ready", 64'(io_in_0_acquire_ready), 64'd0);
        checkOutput("rst_gnt0_valid", 64'(io_in_0_grant_valid), 64'd0);
        reset = 1'b0;
        tick();

        // Simultaneous single-beat Gets: client 0 first, then client 1.
        applyStimulus(0, 1'b1, 3'd0, 3'd0, 26'h100);
        applyStimulus(1, 1'b1, 3'd0, 3'd0, 26'h200);
        io_out_acquire_ready = 1'b0;
        settle();
        checkOutput("bp_out_valid", 64'(io_out_acquire_valid), 64'd1);
        checkOutput("bp_in0_ready", 64'(io_in_0_acquire_ready), 64'd0);
        io_out_acquire_ready = 1'b1;
        settle();
        checkOutput("rr_first_id", 64'(io_out_acquire_bits_client_id), 64'd0);
        checkOutput("rr_first_addr", 64'(io_out_acquire_bits_addr_block), 64'h100);
        checkOutput("rr_first_in0_ready", 64'(io_in_0_acquire_ready), 64'd1);
        checkOutput("rr_first_in1_ready", 64'(io_in_1_acquire_ready), 64'd0);
        tick();
        settle();
        checkOutput("rr_second_id", 64'(io_out_acquire_bits_client_id), 64'd1);
        checkOutput("rr_second_in1_ready", 64'(io_in_1_acquire_ready), 64'd1);
        checkOutput("rr_second_in0_ready", 64'(io_in_0_acquire_ready), 64'd0);
        checkOutput("rr_second_data", io_out_acquire_bits_data, {32'hC0DE_0001, 6'd0, 26'h200});
        checkOutput("rr_second_union", 64'(io_out_acquire_bits_union), 64'hA51);
        tick();
        applyStimulus(0, 1'b0, 3'd0, 3'd0, 26'd0);
        applyStimulus(1, 1'b0, 3'd0, 3'd0, 26'd0);

        // Client 0 Put-block; client 1 joins at beat 2 and must wait for beat 7.
        for (int b = 0; b < 8; b++) begin
            applyStimulus(0, 1'b1, 3'd3, 3'(b), 26'h300);
            if (b >= 2) applyStimulus(1, 1'b1, 3'd0, 3'd0, 26'h400);
            settle();
            checkOutput($sformatf("burst_id_%0d", b), 64'(io_out_acquire_bits_client_id), 64'd0);
            checkOutput($sformatf("burst_beat_%0d", b), 64'(io_out_acquire_bits_addr_beat), 64'(b));
            checkOutput($sformatf("burst_in0_ready_%0d", b), 64'(io_in_0_acquire_ready), 64'd1);
            if (b >= 2)
                checkOutput($sformatf("burst_in1_blocked_%0d", b), 64'(io_in_1_acquire_ready), 64'd0);
            tick();
        end
        applyStimulus(0, 1'b0, 3'd0, 3'd0, 26'd0);
        settle();
        checkOutput("post_burst_id", 64'(io_out_acquire_bits_client_id), 64'd1);
        checkOutput("post_burst_in1_ready", 64'(io_in_1_acquire_ready), 64'd1);
        tick();
        applyStimulus(1, 1'b0, 3'd0, 3'd0, 26'd0);
        applyStimulus(0, 1'b1, 3'd0, 3'd0, 26'h110);
        settle();
        checkOutput("cap0_held_valid", 64'(io_out_acquire_valid), 64'd0);

        // Client 1 outstanding cap and grant release.
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1'b1, 3'd0, 3'd0, 26'(32'h500 + i));
            settle();
            checkOutput($sformatf("cap1_ready_%0d", i), 64'(io_in_1_acquire_ready), 64'd1);
            tick();
        end
        settle();
        checkOutput("cap1_held_ready", 64'(io_in_1_acquire_ready), 64'd0);
        checkOutput("cap1_held_valid", 64'(io_out_acquire_valid), 64'd0);
        tick();
        applyGrant(1'b1, 1'b1, 4'd0, 3'd0);
        io_in_1_grant_ready = 1'b0;
        settle();
        checkOutput("gnt_ready_follow", 64'(io_out_grant_ready), 64'd0);
        io_in_1_grant_ready = 1'b1;
        settle();
        checkOutput("gnt1_valid", 64'(io_in_1_grant_valid), 64'd1);
        checkOutput("gnt0_valid", 64'(io_in_0_grant_valid), 64'd0);
        checkOutput("gnt_ready", 64'(io_out_grant_ready), 64'd1);
        checkOutput("cap1_same_cycle", 64'(io_in_1_acquire_ready), 64'd0);
        tick();
        applyGrant(1'b0, 1'b0, 4'd0, 3'd0);
        settle();
        checkOutput("cap1_reenabled", 64'(io_in_1_acquire_ready), 64'd1);
        tick();

        // 8-beat data grant to client 1 frees one slot only after the last beat.
        for (int b = 0; b < 8; b++) begin
            applyGrant(1'b1, 1'b1, 4'd5, 3'(b));
            settle();
            checkOutput($sformatf("mb_gnt1_valid_%0d", b), 64'(io_in_1_grant_valid), 64'd1);
            checkOutput($sformatf("mb_gnt0_valid_%0d", b), 64'(io_in_0_grant_valid), 64'd0);
            checkOutput($sformatf("mb_gnt_data_%0d", b), io_in_1_grant_bits_data,
                        {32'hBEEF_0000, 29'd0, 3'(b)});
            checkOutput($sformatf("mb_hold_%0d", b), 64'(io_in_1_acquire_ready), 64'd0);
            tick();
        end
        applyGrant(1'b0, 1'b0, 4'd0, 3'd0);
        settle();
        checkOutput("mb_dec_after_last", 64'(io_in_1_acquire_ready), 64'd1);
        tick();

        // Reset at beat 4 of a client 1 burst.
        doReset();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 1'b1, 3'd3, 3'(b), 26'h600);
            tick();
        end
        applyStimulus(1, 1'b1, 3'd3, 3'd4, 26'h600);
        applyStimulus(0, 1'b1, 3'd0, 3'd0, 26'h700);
        settle();
        checkOutput("lock_in0_blocked", 64'(io_in_0_acquire_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1, 1'b1, 3'd0, 3'd0, 26'h610);
        settle();
        checkOutput("rst_mid_id", 64'(io_out_acquire_bits_client_id), 64'd0);
        checkOutput("rst_mid_in0_ready", 64'(io_in_0_acquire_ready), 64'd1);
        checkOutput("rst_mid_in1_ready", 64'(io_in_1_acquire_ready), 64'd0);
        checkOutput("rst_mid_addr", 64'(io_out_acquire_bits_addr_block), 64'h700);
        tick();

        // Client 0 acquire and grant complete together at cnt_0 == 1.
        applyStimulus(1, 1'b0, 3'd0, 3'd0, 26'd0);
        applyStimulus(0, 1'b1, 3'd0, 3'd0, 26'h710);
        applyGrant(1'b1, 1'b0, 4'd0, 3'd0);
        settle();
        checkOutput("same_in0_ready", 64'(io_in_0_acquire_ready), 64'd1);
        checkOutput("same_gnt0_valid", 64'(io_in_0_grant_valid), 64'd1);
        tick();
        applyGrant(1'b0, 1'b0, 4'd0, 3'd0);
        settle();
        checkOutput("same_keep_ready", 64'(io_in_0_acquire_ready), 64'd1);
        tick();
        settle();
        checkOutput("same_cap_held", 64'(io_in_0_acquire_ready), 64'd0);
        applyStimulus(0, 1'b0, 3'd0, 3'd0, 26'd0);

        // Finish channel: client 0 has fixed priority.
        io_in_0_finish_valid = 1'b1;
        io_in_0_finish_bits_manager_xact_id = 2'd1;
        io_in_1_finish_valid = 1'b1;
        io_in_1_finish_bits_manager_xact_id = 2'd2;
        settle();
        checkOutput("fin_both_valid", 64'(io_out_finish_valid), 64'd1);
        checkOutput("fin_both_id", 64'(io_out_finish_bits_manager_xact_id), 64'd1);
        checkOutput("fin_both_ready0", 64'(io_in_0_finish_ready), 64'd1);
        checkOutput("fin_both_ready1", 64'(io_in_1_finish_ready), 64'd0);
        io_in_0_finish_valid = 1'b0;
        settle();
        checkOutput("fin_one_id", 64'(io_out_finish_bits_manager_xact_id), 64'd2);
        checkOutput("fin_one_ready1", 64'(io_in_1_finish_ready), 64'd1);
        io_out_finish_ready = 1'b0;
        settle();
        checkOutput("fin_bp_ready1", 64'(io_in_1_finish_ready), 64'd0);
        io_in_1_finish_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mmio_acquire_arbiter.md
# mmio_acquire_arbiter

Two-client arbiter in front of the MMIO TileLink manager's inner port. It merges two uncached TileLink clients onto one inner acquire channel using round-robin selection. A Put-block burst stays locked to one client until its final beat, so bursts are never interleaved. Grants are steered back by `client_id`, and outstanding transactions are capped per client.

## Interface
Parameters:
- `BEATS`, 8: beats per block; last beat index is `BEATS-1`.
- `MAX_OUTSTANDING`, 2: outstanding acquires allowed per client (1..3).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `io_in_<k>_acquire_valid` / `_ready` (k=0,1) in / out 1: client acquire handshake.
- `io_in_<k>_acquire_bits_{addr_block 26, client_xact_id 1, addr_beat 3, is_builtin_type 1, a_type 3, union 12, data 64}` in: client acquire payload.
- `io_out_acquire_valid` / `_ready` out / in 1: acquire handshake toward the manager.
- `io_out_acquire_bits_*` out: selected client's payload, same fields and widths, plus `client_id` 1 set to the selected k.
- `io_out_grant_valid` / `_ready` in / out 1: grant handshake from the manager.
- `io_out_grant_bits_{addr_beat 3, client_xact_id 1, manager_xact_id 2, is_builtin_type 1, g_type 4, data 64, client_id 1}` in: grant payload from the manager.
- `io_in_<k>_grant_valid` / `_ready` out / in 1: per-client grant handshake.
- `io_in_<k>_grant_bits_*` out: grant fields copied unchanged, excluding `client_id`.
- `io_in_<k>_finish_valid` / `_ready` in / out 1, `io_in_<k>_finish_bits_manager_xact_id` in 2: per-client finish channel.
- `io_out_finish_valid` / `_ready` out / in 1, `io_out_finish_bits_manager_xact_id` out 2: finish toward the manager.

## Operation
Definitions:
- Multibeat acquire: `is_builtin_type==1 && a_type==3`.
- Acquire "completes" on a fire that is not multibeat, or on a multibeat fire with `addr_beat==BEATS-1`.
- Multibeat grant: `is_builtin_type==1 && g_type==5`.
- Grant "completes" on a fire that is not multibeat, or on a multibeat fire with `addr_beat==BEATS-1`.

State registers:
- `lock` (1b), `owner` (1b), `rr_ptr` (1b).
- `cnt_0`, `cnt_1`: 2b each.

FSM states:
- IDLE (`lock=0`).
- BURST (`lock=1`).

Eligibility: client k is eligible when `io_in_k_acquire_valid && (cnt_k < MAX_OUTSTANDING || (lock && owner==k))`.

IDLE behaviour:
- Select `rr_ptr` if that client is eligible, else the other client if eligible.
- A multibeat fire with `addr_beat==0` and `BEATS>1` moves to BURST with `owner=sel`.
- On completion, `rr_ptr <= ~sel`.

BURST behaviour:
- Only `owner` is selected; the other client's ready is 0.
- On completion, return to IDLE and set `rr_ptr <= ~owner`.

Acquire path:
- `io_out_acquire_valid = eligible(sel)`.
- `io_in_sel_acquire_ready = io_out_acquire_ready && eligible(sel)`.
- The non-selected client's ready is 0.

Counters:
- `cnt_k` increments on completion of an acquire from k.
- `cnt_k` decrements on completion of a grant with `client_id==k`.
- Increment and decrement in the same cycle leave the count unchanged.
- Count never wraps. Decrement at 0 is an error: hold 0, and an assertion flags it.

Grant path:
- `io_in_k_grant_valid = io_out_grant_valid && client_id==k`.
- `io_out_grant_ready = io_in_<client_id>_grant_ready`.

Finish path:
- Fixed priority, client 0 over client 1. Combinational, no state.

## Timing
- Acquire and grant paths are combinational, with zero latency. There is no ready-from-valid loop on the out side.
- Lock, pointer and counter updates take effect on the edge after the fire.
- Reset values: `lock=0`, `owner=0`, `rr_ptr=0`, `cnt_*=0`.
- Outputs during reset follow the combinational rules with the reset state applied.
- Reset mid-burst abandons the lock; the next cycle is IDLE with client 0 preferred.
- Both clients valid in IDLE: `rr_ptr` wins.
- A non-owner arrival during BURST waits; it is not dropped and cannot starve, because round-robin alternation resumes after the burst.

## Structure
- Shared package holds:
  - `A_TYPE_PUT_BLOCK=3`, `G_TYPE_GET_DATA_BLOCK=5`.
  - Field widths 26/3/12/64.
  - Helpers `acq_done` and `gnt_done`.
- One sub-module, `rr_lock_arbiter`: pointer, lock FSM and select logic. The top level holds counters and grant/finish steering.

## Test plan
- Both clients issue a single-beat Get in the same cycle after reset -> client 0 fires first, client 1 on the next cycle; `client_id` = 0, then 1.
- Client 0 sends an 8-beat Put-block while client 1 is valid from beat 2 -> beats 0..7 from client 0 are contiguous; client 1 fires in the cycle after beat 7.
- Client 1 issues 2 Gets without grants, `MAX_OUTSTANDING=2` -> the third acquire is held off. A grant with `client_id=1`, `g_type=0` re-enables it the next cycle.
- Manager returns an 8-beat grant (`g_type=5`) with `client_id=1` -> only `io_in_1_grant_valid` pulses. `cnt_1` decrements once, after beat 7.
- Reset asserted at beat 4 of a client 1 burst -> cycle after reset: `lock=0`, counts 0, client 0 wins a simultaneous request.
- Acquire completion and grant completion for client 0 in the same cycle with `cnt_0=1` -> `cnt_0` stays 1.
